// File: rtl/ook_tx_key_ctrl.sv
// Key-driven transmit sequencer for the OOK frame transmitter: start/stop and
// rate keys in, one-cycle frame requests out, with busy/done handshake checking.
module ook_tx_key_ctrl #(
    parameter int GAP_CYCLES  = 62500,  // >= 2
    parameter int ACK_TIMEOUT = 16,     // >= 2
    parameter int NUM_RATES   = 4,      // 2..4
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_key_pulse,
    input  logic             mode_key_pulse,
    input  logic             cont_en,
    input  logic             tx_busy,
    input  logic             tx_done,
    output logic             tx_start,
    output logic [1:0]       rate_sel,
    output logic             ctrl_active,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             err
);

    localparam int TMR_MAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
    localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

    // Both timers count from 0 in the first cycle of their state. The request
    // cycle counts toward the ack window and the done cycle toward the gap, so
    // each terminal value sits two below the parameter.
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 2);
    localparam logic [TMR_W-1:0] ACK_LAST  = TMR_W'(ACK_TIMEOUT - 2);
    localparam logic [1:0]       RATE_LAST = 2'(NUM_RATES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_ACK,
        S_TX,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             cont_q, cont_d;
    logic             stop_req_q, stop_req_d;
    logic [1:0]       rate_q, rate_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             tx_start_q;
    logic             active_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        timer_d    = timer_q;
        cont_d     = cont_q;
        stop_req_d = stop_req_q;
        rate_d     = rate_q;
        cnt_d      = cnt_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (mode_key_pulse) begin
                    rate_d = (rate_q == RATE_LAST) ? 2'd0 : rate_q + 2'd1;
                end
                if (start_key_pulse) begin
                    state_d    = S_REQ;
                    cont_d     = cont_en;
                    err_d      = 1'b0;
                    stop_req_d = 1'b0;
                end
            end
            S_REQ: begin
                if (start_key_pulse) stop_req_d = 1'b1;
                state_d = S_WAIT_ACK;
                timer_d = '0;
            end
            S_WAIT_ACK: begin
                if (start_key_pulse) stop_req_d = 1'b1;
                if (tx_busy) begin
                    state_d = S_TX;
                end else if (timer_q == ACK_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_TX: begin
                if (start_key_pulse) stop_req_d = 1'b1;
                if (tx_done) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    timer_d = '0;
                    // A stop arriving with the done pulse must also end the run.
                    if (cont_q && !stop_req_q && !start_key_pulse) state_d = S_GAP;
                    else                                             state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (stop_req_q || start_key_pulse) begin
                    state_d = S_IDLE;
                end else if (timer_q == GAP_LAST) begin
                    state_d = S_REQ;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            cont_q     <= 1'b0;
            stop_req_q <= 1'b0;
            rate_q     <= 2'd0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            tx_start_q <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cont_q     <= cont_d;
            stop_req_q <= stop_req_d;
            rate_q     <= rate_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            // Decoded from next state so the flags line up with the state they describe.
            tx_start_q <= (state_d == S_REQ);
            active_q   <= (state_d != S_IDLE);
        end
    end

    assign tx_start    = tx_start_q;
    assign rate_sel    = rate_q;
    assign ctrl_active = active_q;
    assign frame_cnt   = cnt_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ook_tx_key_ctrl.sv
// Bench for ook_tx_key_ctrl: a transmitter responder, a rate-select vector table,
// hand-written handshake/stop/reset/wrap sequences and a randomized transaction model.
module tb_ook_tx_key_ctrl;

    localparam int GAP = 8;
    localparam int ACK = 4;
    localparam int NR  = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_key_pulse = 1'b0;
    logic          mode_key_pulse = 1'b0;
    logic          cont_en = 1'b0;
    logic          tx_busy = 1'b0;
    logic          tx_done = 1'b0;
    logic          tx_start;
    logic [1:0]    rate_sel;
    logic          ctrl_active;
    logic [CW-1:0] frame_cnt;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int st_q[$];
    int dn_q[$];

    // Responder knobs: busy rises rsp_delay cycles after tx_start (0 = never),
    // tx_done pulses rsp_len cycles after that, busy drops the cycle after done.
    int rsp_delay = 2;
    int rsp_len = 20;
    int rsp_cnt = -1;

    int exp_cnt = 0;
    int exp_rate = 0;

    typedef struct {
        logic       start;
        logic       mode;
        logic [1:0] exp_rate;
        logic       exp_tx;
        logic       exp_act;
    } vec_t;
    vec_t vecs [11];

    always #5 clk = ~clk;

    ook_tx_key_ctrl #(
        .GAP_CYCLES (GAP),
        .ACK_TIMEOUT(ACK),
        .NUM_RATES  (NR),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_key_pulse(start_key_pulse),
        .mode_key_pulse (mode_key_pulse),
        .cont_en        (cont_en),
        .tx_busy        (tx_busy),
        .tx_done        (tx_done),
        .tx_start       (tx_start),
        .rate_sel       (rate_sel),
        .ctrl_active    (ctrl_active),
        .frame_cnt      (frame_cnt),
        .err            (err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_start) st_q.push_back(cyc);
        if (tx_done)  dn_q.push_back(cyc);
    end

    initial begin : responder
        forever begin
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            if (tx_start) begin
                rsp_cnt = 0;
                tx_busy = 1'b0;
            end else if (rsp_cnt >= 0) begin
                rsp_cnt++;
            end
            if (rsp_cnt >= 0) begin
                if (rsp_delay == 0)                          rsp_cnt = -1;
                else if (rsp_cnt == rsp_delay)               tx_busy = 1'b1;
                else if (rsp_cnt == rsp_delay + rsp_len)     tx_done = 1'b1;
                else if (rsp_cnt > rsp_delay + rsp_len) begin
                    tx_busy = 1'b0;
                    rsp_cnt = -1;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic with_mode);
        start_key_pulse = 1'b1;
        mode_key_pulse  = with_mode;
        step();
        start_key_pulse = 1'b0;
        mode_key_pulse  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget && ctrl_active; i++) step();
        check({name, " idle"}, 32'(ctrl_active), 0);
    endtask

    initial begin : main
        int n0;
        int n_mode;
        int dly;
        int len;
        logic coin;

        // ---------------- reset state ----------------
        step(3);
        check("rst tx_start", 32'(tx_start), 0);
        check("rst rate_sel", 32'(rate_sel), 0);
        check("rst active", 32'(ctrl_active), 0);
        check("rst frame_cnt", 32'(frame_cnt), 0);
        check("rst err", 32'(err), 0);
        rst_n = 1'b1;

        // ---------------- single shot ----------------
        rsp_delay = 2;
        rsp_len   = 20;
        cont_en   = 1'b0;
        step(9);
        pulse_start(1'b0);
        check("ss tx_start", 32'(tx_start), 1);
        check("ss active", 32'(ctrl_active), 1);
        step();
        check("ss tx_start single", 32'(tx_start), 0);
        step(20);
        check("ss active before done", 32'(ctrl_active), 1);
        step();
        check("ss active at done", 32'(ctrl_active), 1);
        check("ss cnt at done", 32'(frame_cnt), 0);
        step();
        exp_cnt = 1;
        check("ss active after done", 32'(ctrl_active), 0);
        check("ss frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        check("ss start count", 32'(st_q.size()), 1);

        // ---------------- rate select table ----------------
        vecs[0]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 2'd2, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1};
        for (int i = 0; i < 11; i++) begin
            start_key_pulse = vecs[i].start;
            mode_key_pulse  = vecs[i].mode;
            step();
            start_key_pulse = 1'b0;
            mode_key_pulse  = 1'b0;
            check($sformatf("vec%0d rate_sel", i), 32'(rate_sel), 32'(vecs[i].exp_rate));
            check($sformatf("vec%0d tx_start", i), 32'(tx_start), 32'(vecs[i].exp_tx));
            check($sformatf("vec%0d active", i), 32'(ctrl_active), 32'(vecs[i].exp_act));
        end
        wait_idle("rate frame", 60);
        exp_cnt  = (exp_cnt + 1) % (1 << CW);
        exp_rate = 2;
        check("rate frame cnt", 32'(frame_cnt), 32'(exp_cnt));

        // ---------------- continuous with stop ----------------
        st_q.delete();
        dn_q.delete();
        cont_en = 1'b1;
        pulse_start(1'b0);
        cont_en = 1'b0;
        for (int i = 0; i < 400 && st_q.size() < 3; i++) step();
        check("cont third start seen", 32'(st_q.size()), 3);
        step(5);
        pulse_start(1'b0);
        wait_idle("cont stop", 100);
        step(30);
        check("cont start count", 32'(st_q.size()), 3);
        check("cont done count", 32'(dn_q.size()), 3);
        if (st_q.size() == 3 && dn_q.size() == 3) begin
            check("cont gap 1", 32'(st_q[1] - dn_q[0]), GAP);
            check("cont gap 2", 32'(st_q[2] - dn_q[1]), GAP);
        end
        exp_cnt = (exp_cnt + 3) % (1 << CW);
        check("cont frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

        // ---------------- ack timeout ----------------
        rsp_delay = 0;
        pulse_start(1'b0);
        check("to tx_start", 32'(tx_start), 1);
        step();
        check("to err early", 32'(err), 0);
        step(2);
        check("to err before limit", 32'(err), 0);
        check("to active before limit", 32'(ctrl_active), 1);
        step();
        check("to err set", 32'(err), 1);
        check("to active", 32'(ctrl_active), 0);
        check("to tx_start idle", 32'(tx_start), 0);
        step(3);
        check("to err sticky", 32'(err), 1);
        rsp_delay = 2;
        pulse_start(1'b0);
        check("to restart tx_start", 32'(tx_start), 1);
        check("to err cleared", 32'(err), 0);
        wait_idle("to restart", 60);
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        check("to restart cnt", 32'(frame_cnt), 32'(exp_cnt));

        // ---------------- reset mid-frame ----------------
        pulse_start(1'b0);
        step(6);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr tx_start", 32'(tx_start), 0);
        check("mr rate_sel", 32'(rate_sel), 0);
        check("mr active", 32'(ctrl_active), 0);
        check("mr frame_cnt", 32'(frame_cnt), 0);
        check("mr err", 32'(err), 0);
        step(3);
        rst_n = 1'b1;
        exp_cnt  = 0;
        exp_rate = 0;
        n0 = st_q.size();
        step(30);
        check("mr late done ignored", 32'(frame_cnt), 0);
        check("mr no new start", 32'(st_q.size()), 32'(n0));
        check("mr still idle", 32'(ctrl_active), 0);

        // ---------------- counter wrap ----------------
        rsp_delay = 1;
        rsp_len   = 3;
        for (int f = 0; f < 17; f++) begin
            pulse_start(1'b0);
            wait_idle($sformatf("wrap frame %0d", f), 30);
        end
        exp_cnt = 17 % (1 << CW);
        check("wrap frame_cnt", 32'(frame_cnt), 1);

        // ---------------- randomized transactions ----------------
        for (int t = 0; t < 40; t++) begin
            n_mode = $urandom_range(0, 3);
            coin   = 1'($urandom_range(0, 1));
            dly    = $urandom_range(1, 5);
            len    = $urandom_range(1, 6);
            rsp_delay = dly;
            rsp_len   = len;
            for (int m = 0; m < n_mode; m++) begin
                mode_key_pulse = 1'b1;
                step();
                mode_key_pulse = 1'b0;
                step($urandom_range(0, 2));
            end
            exp_rate = (exp_rate + n_mode + int'(coin)) % NR;
            pulse_start(coin);
            check($sformatf("rnd%0d tx_start", t), 32'(tx_start), 1);
            check($sformatf("rnd%0d rate at start", t), 32'(rate_sel), 32'(exp_rate));
            if ($urandom_range(0, 1) == 1) begin
                mode_key_pulse = 1'b1;
                step();
                mode_key_pulse = 1'b0;
            end
            wait_idle($sformatf("rnd%0d", t), 40);
            // Busy is honoured only if it shows up before the ack window closes.
            if (dly <= ACK - 1) exp_cnt = (exp_cnt + 1) % (1 << CW);
            check($sformatf("rnd%0d frame_cnt", t), 32'(frame_cnt), 32'(exp_cnt));
            check($sformatf("rnd%0d err", t), 32'(err), (dly <= ACK - 1) ? 0 : 1);
            check($sformatf("rnd%0d rate after", t), 32'(rate_sel), 32'(exp_rate));
            if (dly > ACK - 1) step(12);
            else               step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
